// File: rtl/ultrasonic_ranger_ctrl_if.sv
// Sensor-side and status signals of the ultrasonic ranger.
// slave: the ranger controller. master: whatever drives the pins and reads the result.
interface ultrasonic_ranger_ctrl_if;
  logic        start;
  logic        continuous;
  logic        echo;
  logic        trig;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [12:0] echo_time;

  modport slave (
    input  start,
    input  continuous,
    input  echo,
    output trig,
    output busy,
    output done,
    output timeout,
    output echo_time
  );

  modport master (
    output start,
    output continuous,
    output echo,
    input  trig,
    input  busy,
    input  done,
    input  timeout,
    input  echo_time
  );
endinterface

// File: rtl/ultrasonic_ranger_ctrl.sv
// Ultrasonic ranger controller: trigger pulse, echo wait, echo width timing in prescaled ticks,
// result publication and a hold-off before the next shot (single-shot or continuous).
// Optional macro RANGER_AVG_EN: echo_time becomes the mean of the last 4 valid measurements.
module ultrasonic_ranger_ctrl #(
  parameter int unsigned TICK_DIV      = 50,
  parameter int unsigned TRIG_CYCLES   = 500,
  parameter int unsigned TIMEOUT_TICKS = 8000,
  parameter int unsigned HOLDOFF_TICKS = 4095
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  ultrasonic_ranger_ctrl_if.slave bus
);

  localparam int unsigned PrescW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TrigW  = (TRIG_CYCLES > 2) ? $clog2(TRIG_CYCLES) : 1;

  localparam logic [PrescW-1:0] PrescLast  = PrescW'(TICK_DIV - 1);
  localparam logic [TrigW-1:0]  TrigLast   = TrigW'(TRIG_CYCLES - 1);
  localparam logic [12:0]       TimerMax   = 13'h1fff;
  localparam logic [12:0]       TimeoutVal = 13'(TIMEOUT_TICKS);
  localparam logic [12:0]       HoldoffVal = 13'(HOLDOFF_TICKS);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StHoldoff
  } state_e;

  state_e            state_q;
  logic              trig_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [12:0]       echo_time_q;
  logic [PrescW-1:0] presc_q;
  logic [12:0]       timer_q;
  logic [TrigW-1:0]  trig_cnt_q;
  logic              shot_done_q;

  logic              echo_s1_q, echo_s2_q, echo_d1_q;
  logic              echo_rise, echo_fall, tick;
  logic [PrescW-1:0] presc_run;
  logic [12:0]       timer_run;
  logic [12:0]       result;

  // Two-flop synchroniser for the raw echo plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_d1_q <= 1'b0;
    end else begin
      echo_s1_q <= bus.echo;
      echo_s2_q <= echo_s1_q;
      echo_d1_q <= echo_s2_q;
    end
  end

  // Edge strobes and free-running prescaler/timer next values (timer saturates, never wraps).
  always_comb begin
    echo_rise = echo_s2_q & ~echo_d1_q;
    echo_fall = ~echo_s2_q & echo_d1_q;
    tick      = (presc_q == PrescLast);
    presc_run = tick ? '0 : presc_q + 1'b1;
    timer_run = (tick && timer_q != TimerMax) ? timer_q + 1'b1 : timer_q;
  end

`ifdef RANGER_AVG_EN
  // Three previous valid results; the incoming measurement is the fourth entry.
  logic [12:0] hist_q [3];
  logic        hist_vld_q;
  logic [14:0] avg_sum;

  // Averaged result; the very first valid measurement stands for all four entries.
  always_comb begin
    avg_sum = 15'(timer_q) + 15'(hist_q[0]) + 15'(hist_q[1]) + 15'(hist_q[2]);
    result  = hist_vld_q ? 13'(avg_sum >> 2) : timer_q;
  end

  // History update on each valid (non-timeout) measurement only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q[0]  <= '0;
      hist_q[1]  <= '0;
      hist_q[2]  <= '0;
      hist_vld_q <= 1'b0;
    end else if (state_q == StMeasure && echo_fall) begin
      hist_vld_q <= 1'b1;
      hist_q[0]  <= timer_q;
      hist_q[1]  <= hist_vld_q ? hist_q[0] : timer_q;
      hist_q[2]  <= hist_vld_q ? hist_q[1] : timer_q;
    end
  end
`else
  // Raw latest measurement.
  always_comb begin
    result = timer_q;
  end
`endif

  // Shot sequencer with registered outputs; counters cleared on every state entry that needs it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      echo_time_q <= '0;
      presc_q     <= '0;
      timer_q     <= '0;
      trig_cnt_q  <= '0;
      shot_done_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      presc_q <= presc_run;
      timer_q <= timer_run;
      case (state_q)
        StIdle: begin
          // continuous alone only relaunches once a shot has completed since reset
          if (bus.start || (bus.continuous && shot_done_q)) begin
            state_q    <= StTrig;
            trig_q     <= 1'b1;
            busy_q     <= 1'b1;
            trig_cnt_q <= '0;
            presc_q    <= '0;
            timer_q    <= '0;
          end
        end
        StTrig: begin
          if (trig_cnt_q == TrigLast) begin
            state_q <= StWaitRise;
            trig_q  <= 1'b0;
            presc_q <= '0;
            timer_q <= '0;
          end else begin
            trig_cnt_q <= trig_cnt_q + 1'b1;
          end
        end
        StWaitRise: begin
          // rising edge takes priority over a coincident timeout
          if (echo_rise) begin
            state_q <= StMeasure;
            presc_q <= '0;
            timer_q <= '0;
          end else if (timer_q == TimeoutVal) begin
            state_q     <= StHoldoff;
            timeout_q   <= 1'b1;
            done_q      <= 1'b1;
            shot_done_q <= 1'b1;
            presc_q     <= '0;
            timer_q     <= '0;
          end
        end
        StMeasure: begin
          if (echo_fall) begin
            state_q     <= StHoldoff;
            echo_time_q <= result;
            timeout_q   <= 1'b0;
            done_q      <= 1'b1;
            shot_done_q <= 1'b1;
            presc_q     <= '0;
            timer_q     <= '0;
          end else if (timer_q == TimeoutVal) begin
            state_q     <= StHoldoff;
`ifndef RANGER_AVG_EN
            echo_time_q <= TimeoutVal;
`endif
            timeout_q   <= 1'b1;
            done_q      <= 1'b1;
            shot_done_q <= 1'b1;
            presc_q     <= '0;
            timer_q     <= '0;
          end
        end
        StHoldoff: begin
          if (timer_q == HoldoffVal) begin
            if (bus.continuous) begin
              state_q    <= StTrig;
              trig_q     <= 1'b1;
              trig_cnt_q <= '0;
              presc_q    <= '0;
              timer_q    <= '0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          trig_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig      = trig_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.echo_time = echo_time_q;

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Directed bench for ultrasonic_ranger_ctrl with TICK_DIV=2, TRIG_CYCLES=5, TIMEOUT_TICKS=100,
// HOLDOFF_TICKS=10. Echo widths map to roughly width/2 ticks; echo_time is checked to +/-1.
module tb_ultrasonic_ranger_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   nchecks = 0;
  int   nerr    = 0;

  ultrasonic_ranger_ctrl_if rif ();

  ultrasonic_ranger_ctrl #(
    .TICK_DIV      (2),
    .TRIG_CYCLES   (5),
    .TIMEOUT_TICKS (100),
    .HOLDOFF_TICKS (10)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (rif)
  );

  always #5 clk = ~clk;

`ifdef RANGER_AVG_EN
  localparam int Exp4     = 30;
  localparam int Exp4Tol  = 1;
  localparam int Exp5 [3] = '{20, 25, 35};
  localparam int Exp6 [4] = '{20, 20, 20, 40};
`else
  localparam int Exp4     = 100;
  localparam int Exp4Tol  = 0;
  localparam int Exp5 [3] = '{20, 40, 60};
  localparam int Exp6 [4] = '{20, 20, 20, 100};
`endif
  localparam int W5 [3] = '{40, 80, 120};
  localparam int W6 [4] = '{40, 40, 40, 200};

  task automatic chk(input string tag, input int obs, input int exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    nchecks++;
    assert (obs >= lo && obs <= hi) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic pulse_start();
    rif.start = 1'b1;
    @(negedge clk);
    rif.start = 1'b0;
  endtask

  task automatic wait_trig_rise(input string tag, input int budget, output int n);
    n = 0;
    while (!rif.trig && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_trig_rise"}, int'(rif.trig), 1);
  endtask

  task automatic wait_trig_fall(input string tag, input int budget, output int n);
    n = 0;
    while (rif.trig && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_trig_fall"}, int'(rif.trig), 0);
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (!rif.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, int'(rif.done), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (rif.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_low"}, int'(rif.busy), 0);
  endtask

  // One single-shot measurement: echo rises 20 clk after trig falls and lasts width clk.
  task automatic run_shot(input string tag, input int width, input int exp);
    int n;
    pulse_start();
    wait_trig_rise(tag, 20, n);
    wait_trig_fall(tag, 50, n);
    chk({tag, "_trig_width"}, n, 5);
    repeat (19) @(negedge clk);
    rif.echo = 1'b1;
    repeat (width) @(negedge clk);
    rif.echo = 1'b0;
    wait_done(tag, 50, n);
    chk_range({tag, "_echo_time"}, int'(rif.echo_time), exp - 1, exp + 1);
    chk({tag, "_timeout"}, int'(rif.timeout), 0);
    chk({tag, "_busy_at_done"}, int'(rif.busy), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(rif.done), 0);
    wait_idle(tag, 100);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    rif.start      = 1'b0;
    rif.continuous = 1'b0;
    rif.echo       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", int'(rif.trig), 0);
    chk("rst_busy", int'(rif.busy), 0);
    chk("rst_done", int'(rif.done), 0);
    chk("rst_timeout", int'(rif.timeout), 0);
    chk("rst_echo_time", int'(rif.echo_time), 0);
    rst_n = 1'b1;

    // continuous alone after reset must not launch
    rif.continuous = 1'b1;
    repeat (10) @(negedge clk);
    chk("cont_alone_busy", int'(rif.busy), 0);
    chk("cont_alone_trig", int'(rif.trig), 0);
    rif.continuous = 1'b0;

    // Reset during TRIG drops trig asynchronously
    pulse_start();
    chk("trig_started", int'(rif.trig), 1);
    chk("busy_started", int'(rif.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_trig_drop", int'(rif.trig), 0);
    chk("async_busy_drop", int'(rif.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: reset mid-MEASURE
    pulse_start();
    wait_trig_fall("t1", 50, n);
    repeat (4) @(negedge clk);
    rif.echo = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_busy", int'(rif.busy), 0);
    rif.echo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t1_idle_busy", int'(rif.busy), 0);
    chk("t1_idle_trig", int'(rif.trig), 0);
    chk("t1_echo_time", int'(rif.echo_time), 0);
    chk("t1_timeout", int'(rif.timeout), 0);
    chk("t1_done", int'(rif.done), 0);

    // Test 2: 60 clk echo -> ~30 ticks
    run_shot("t2", 60, 30);

    // Test 3: echo never rises -> timeout after ~100 ticks in WAIT_RISE
    pulse_start();
    wait_trig_fall("t3", 50, n);
    wait_done("t3", 400, n);
    chk_range("t3_wait_clks", n, 199, 203);
    chk("t3_timeout", int'(rif.timeout), 1);
    chk_range("t3_echo_time_kept", int'(rif.echo_time), 29, 31);
    wait_idle("t3", 100);

    // Test 4: echo never falls -> MEASURE timeout
    pulse_start();
    wait_trig_fall("t4", 50, n);
    repeat (10) @(negedge clk);
    rif.echo = 1'b1;
    wait_done("t4", 400, n);
    chk_range("t4_echo_time", int'(rif.echo_time), Exp4 - Exp4Tol, Exp4 + Exp4Tol);
    chk("t4_timeout", int'(rif.timeout), 1);
    rif.echo = 1'b0;
    wait_idle("t4", 100);

    // Test 5: continuous ranging, three shots after a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rif.continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_trig_rise("t5", 200, n);
      if (i > 0) chk_range("t5_holdoff_gap", n, 20, 23);
      if (i == 2) rif.continuous = 1'b0;
      wait_trig_fall("t5", 50, n);
      repeat (10) @(negedge clk);
      rif.echo = 1'b1;
      repeat (W5[i]) @(negedge clk);
      rif.echo = 1'b0;
      wait_done("t5", 50, n);
      chk_range("t5_echo_time", int'(rif.echo_time), Exp5[i] - 1, Exp5[i] + 1);
      chk("t5_timeout", int'(rif.timeout), 0);
      if (i < 2) @(negedge clk);
    end
    wait_idle("t5", 100);
    repeat (30) @(negedge clk);
    chk("t5_stopped_trig", int'(rif.trig), 0);

    // Test 6: widths 40, 40, 40, 200 after a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_shot("t6", W6[i], Exp6[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
